axi_led_pwm: RTL

//  AXI4-Lite slave driving LED_NBR_p LEDs, each with its own PWM brightness. Successor to the

---
 rtl/axi_led_pwm_if.sv | 33 +++
 rtl/axi_led_pwm.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_led_pwm_if.sv
// AXI4-Lite register bus for axi_led_pwm. The slave modport is the LED block;
// the master modport is the interconnect or bench.
interface axi_led_pwm_if #(parameter int AXI_ADDR_BW_p = 12);
  logic [AXI_ADDR_BW_p-1:0] i_axi_awaddr;
  logic                     i_axi_awvalid;
  logic                     o_axi_awready;
  logic [31:0]              i_axi_wdata;
  logic                     i_axi_wvalid;
  logic                     o_axi_wready;
  logic [1:0]               o_axi_bresp;
  logic                     o_axi_bvalid;
  logic                     i_axi_bready;
  logic [AXI_ADDR_BW_p-1:0] i_axi_araddr;
  logic                     i_axi_arvalid;
  logic                     o_axi_arready;
  logic [31:0]              o_axi_rdata;
  logic [1:0]               o_axi_rresp;
  logic                     o_axi_rvalid;
  logic                     i_axi_rready;

  modport slave (
    input  i_axi_awaddr, i_axi_awvalid, i_axi_wdata, i_axi_wvalid, i_axi_bready,
           i_axi_araddr, i_axi_arvalid, i_axi_rready,
    output o_axi_awready, o_axi_wready, o_axi_bresp, o_axi_bvalid,
           o_axi_arready, o_axi_rdata, o_axi_rresp, o_axi_rvalid
  );
  modport master (
    output i_axi_awaddr, i_axi_awvalid, i_axi_wdata, i_axi_wvalid, i_axi_bready,
           i_axi_araddr, i_axi_arvalid, i_axi_rready,
    input  o_axi_awready, o_axi_wready, o_axi_bresp, o_axi_bvalid,
           o_axi_arready, o_axi_rdata, o_axi_rresp, o_axi_rvalid
  );
endinterface

// File: rtl/axi_led_pwm.sv
// AXI4-Lite LED PWM controller: per-LED duty bank, global enable/mask and a prescaled PWM counter.
// Define AXI_LED_PWM_BLINK_EN to add BLINK_MASK (0x010) / BLINK_HALF (0x014) blinking.

module axi_led_pwm_fifo2 #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  logic [1:0][W-1:0] mem;
  logic              wp, rp;
  logic [1:0]        cnt;

  always_ff @(posedge clk) if (push) mem[wp] <= din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) wp <= ~wp;
      if (pop)  rp <= ~rp;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout  = mem[rp];
  assign empty = (cnt == 2'd0);
  assign full  = (cnt == 2'd2);
endmodule

module axi_led_pwm_lane #(parameter int PWM_BW_p = 8) (
  input  logic                clk,
  input  logic                rst,
  input  logic                duty_we,
  input  logic [PWM_BW_p:0]   duty_wd,
  input  logic                wrap,
  input  logic [PWM_BW_p-1:0] pwm_cnt,
  input  logic                gate,
  output logic [PWM_BW_p:0]   duty_q,
  output logic                led
);
  logic [PWM_BW_p:0] duty_act;

  // duty_q is the software-visible shadow; duty_act only follows it at the period
  // boundary so a running PWM period never sees a mid-period width change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q   <= '0;
      duty_act <= '0;
      led      <= 1'b0;
    end else begin
      if (duty_we) duty_q   <= duty_wd;
      if (wrap)    duty_act <= duty_q;
      led <= gate & (duty_act > {1'b0, pwm_cnt});
    end
  end
endmodule

module axi_led_pwm #(
  parameter int AXI_ADDR_BW_p = 12,
  parameter int LED_NBR_p     = 8,
  parameter int PWM_BW_p      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_led_pwm_if.slave         axi,
  output logic [LED_NBR_p-1:0] o_led
);
  localparam int AW = AXI_ADDR_BW_p;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  typedef struct packed {
    logic       ok;
    logic       ro;
    logic       duty;
    logic [2:0] sel;
    logic [5:0] idx;
  } dec_t;

  function automatic dec_t decode(input logic [AW-1:0] a);
    dec_t d;
    d     = '0;
    d.sel = a[4:2];
    d.idx = a[7:2];
    if (a[1:0] == 2'b00) begin
      if (a[AW-1:5] == '0) begin
        case (a[4:2])
          3'd0, 3'd1, 3'd2: d.ok = 1'b1;
          3'd3: begin d.ok = 1'b1; d.ro = 1'b1; end
`ifdef AXI_LED_PWM_BLINK_EN
          3'd4, 3'd5: d.ok = 1'b1;
`endif
          default: d.ok = 1'b0;
        endcase
      end else if (a[AW-1:8] == {{(AW-9){1'b0}}, 1'b1} && {26'd0, a[7:2]} < LED_NBR_p) begin
        d.ok   = 1'b1;
        d.duty = 1'b1;
      end
    end
    return d;
  endfunction

  // request FIFOs
  logic [AW-1:0] aw_q, ar_q;
  logic [31:0]   w_q;
  logic          aw_e, w_e, ar_e, aw_f, w_f, ar_f;
  logic          wr_go, rd_go;

  assign axi.o_axi_awready = ~rst & ~aw_f;
  assign axi.o_axi_wready  = ~rst & ~w_f;
  assign axi.o_axi_arready = ~rst & ~ar_f;

  axi_led_pwm_fifo2 #(.W(AW)) u_aw (.clk(clk), .rst(rst),
    .push(axi.i_axi_awvalid & axi.o_axi_awready), .din(axi.i_axi_awaddr),
    .pop(wr_go), .dout(aw_q), .empty(aw_e), .full(aw_f));
  axi_led_pwm_fifo2 #(.W(32)) u_w (.clk(clk), .rst(rst),
    .push(axi.i_axi_wvalid & axi.o_axi_wready), .din(axi.i_axi_wdata),
    .pop(wr_go), .dout(w_q), .empty(w_e), .full(w_f));
  axi_led_pwm_fifo2 #(.W(AW)) u_ar (.clk(clk), .rst(rst),
    .push(axi.i_axi_arvalid & axi.o_axi_arready), .din(axi.i_axi_araddr),
    .pop(rd_go), .dout(ar_q), .empty(ar_e), .full(ar_f));

  dec_t wr_dec, rd_dec;
  logic wr_ok, reg_we;
  assign wr_dec = decode(aw_q);
  assign rd_dec = decode(ar_q);
  assign wr_go  = ~aw_e & ~w_e & (~axi.o_axi_bvalid | axi.i_axi_bready);
  assign rd_go  = ~ar_e & (~axi.o_axi_rvalid | axi.i_axi_rready);
  assign wr_ok  = wr_dec.ok & ~wr_dec.ro;
  assign reg_we = wr_go & wr_ok & ~wr_dec.duty;

  // control registers
  logic                 ctrl_en;
  logic [LED_NBR_p-1:0] led_en;
  logic [15:0]          prescale;
`ifdef AXI_LED_PWM_BLINK_EN
  logic [LED_NBR_p-1:0] blink_mask;
  logic [15:0]          blink_half, blink_cnt;
  logic                 blink_phase;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_en  <= 1'b0;
      led_en   <= '0;
      prescale <= '0;
`ifdef AXI_LED_PWM_BLINK_EN
      blink_mask <= '0;
      blink_half <= '0;
`endif
    end else if (reg_we) begin
      case (wr_dec.sel)
        3'd0: ctrl_en  <= w_q[0];
        3'd1: led_en   <= w_q[LED_NBR_p-1:0];
        3'd2: prescale <= w_q[15:0];
`ifdef AXI_LED_PWM_BLINK_EN
        3'd4: blink_mask <= w_q[LED_NBR_p-1:0];
        3'd5: blink_half <= w_q[15:0];
`endif
        default: ;
      endcase
    end
  end

  // prescaler and PWM counter
  logic [15:0]         psc_cnt;
  logic [PWM_BW_p-1:0] pwm_cnt;
  logic                tick, wrap;
  assign tick = (psc_cnt == prescale);
  assign wrap = tick & (pwm_cnt == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      if (reg_we && wr_dec.sel == 3'd2) psc_cnt <= '0;
      else if (tick)                    psc_cnt <= '0;
      else                              psc_cnt <= psc_cnt + 16'd1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

`ifdef AXI_LED_PWM_BLINK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (wrap) begin
      if (blink_cnt == blink_half) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 16'd1;
      end
    end
  end
`endif

  // per-LED lanes
  logic [LED_NBR_p-1:0][PWM_BW_p:0] duty_q;
  for (genvar i = 0; i < LED_NBR_p; i++) begin : g_lane
    logic gate;
`ifdef AXI_LED_PWM_BLINK_EN
    assign gate = ctrl_en & led_en[i] & ~(blink_mask[i] & blink_phase);
`else
    assign gate = ctrl_en & led_en[i];
`endif
    axi_led_pwm_lane #(.PWM_BW_p(PWM_BW_p)) u_lane (
      .clk(clk), .rst(rst),
      .duty_we(wr_go & wr_ok & wr_dec.duty & (wr_dec.idx == 6'(i))),
      .duty_wd(w_q[PWM_BW_p:0]), .wrap(wrap), .pwm_cnt(pwm_cnt),
      .gate(gate), .duty_q(duty_q[i]), .led(o_led[i]));
  end

  // read mux samples pre-edge state, so a same-cycle write is not yet visible
  logic [31:0] rd_val;
  logic        rd_err;
  always_comb begin
    rd_val = 32'hDEADDEAD;
    rd_err = 1'b1;
    if (rd_dec.ok) begin
      rd_err = 1'b0;
      rd_val = '0;
      if (rd_dec.duty) begin
        for (int i = 0; i < LED_NBR_p; i++)
          if (rd_dec.idx == 6'(i)) rd_val[PWM_BW_p:0] = duty_q[i];
      end else begin
        case (rd_dec.sel)
          3'd0: rd_val[0]              = ctrl_en;
          3'd1: rd_val[LED_NBR_p-1:0]  = led_en;
          3'd2: rd_val[15:0]           = prescale;
          3'd3: rd_val[PWM_BW_p-1:0]   = pwm_cnt;
`ifdef AXI_LED_PWM_BLINK_EN
          3'd4: rd_val[LED_NBR_p-1:0]  = blink_mask;
          3'd5: rd_val[15:0]           = blink_half;
`endif
          default: rd_val = '0;
        endcase
      end
    end
  end

  // response channels: held until accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      axi.o_axi_bvalid <= 1'b0;
      axi.o_axi_bresp  <= OKAY;
      axi.o_axi_rvalid <= 1'b0;
      axi.o_axi_rresp  <= OKAY;
      axi.o_axi_rdata  <= '0;
    end else begin
      if (wr_go) begin
        axi.o_axi_bvalid <= 1'b1;
        axi.o_axi_bresp  <= wr_ok ? OKAY : SLVERR;
      end else if (axi.i_axi_bready) begin
        axi.o_axi_bvalid <= 1'b0;
      end
      if (rd_go) begin
        axi.o_axi_rvalid <= 1'b1;
        axi.o_axi_rdata  <= rd_val;
        axi.o_axi_rresp  <= rd_err ? SLVERR : OKAY;
      end else if (axi.i_axi_rready) begin
        axi.o_axi_rvalid <= 1'b0;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{w_q, rd_dec};
endmodule
